// File: rtl/matrix_pcpi_loader_pkg.sv
// Purpose : shared constants, state encoding and instruction encoder for the
//           matrix PCPI operand loader.
// Ports   : none (package).
package matrix_pcpi_pkg;

  // custom-0 major opcode used by the matrix coprocessor
  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

  localparam logic [2:0] F3_WRITE = 3'b000;
  localparam logic [2:0] F3_CLEAR = 3'b101;
  localparam logic [2:0] F3_START = 3'b111;

  // operand register map inside the coprocessor
  localparam int ADDR_A      = 0;
  localparam int ADDR_B      = 9;
  localparam int ADDR_BIAS   = 18;
  localparam int ADDR_THRESH = 27;

  localparam int ADDR_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    CLEAR
  } state_e;

  // insn = {0, value[15:0], funct3, addr[4:0], custom-0}
  function automatic logic [31:0] encode_insn(input logic [2:0]        funct3,
                                              input logic [ADDR_W-1:0] addr,
                                              input logic [15:0]       value);
    return {1'b0, value, funct3, addr, OPC_CUSTOM0};
  endfunction

endpackage

// File: rtl/matrix_pcpi_loader_if.sv
// Purpose : bundles the job control, operand stream and PCPI signals of the loader.
// Ports   : master = loader side (drives s_ready, pcpi_*, status);
//           slave  = environment side (drives cmd_*, s_valid/s_data, pcpi_wait/ready).
interface matrix_pcpi_loader_if;
  import matrix_pcpi_pkg::*;

  // job control / status
  logic        cmd_start;
  logic        cmd_abort;
  logic        busy;
  logic        done;
  logic        err_timeout;

  // operand stream
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;

  // PCPI towards the coprocessor
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic        pcpi_wait;
  logic        pcpi_ready;

  modport master (
    input  cmd_start, cmd_abort, s_valid, s_data, pcpi_wait, pcpi_ready,
    output s_ready, pcpi_valid, pcpi_insn, busy, done, err_timeout
  );

  modport slave (
    output cmd_start, cmd_abort, s_valid, s_data, pcpi_wait, pcpi_ready,
    input  s_ready, pcpi_valid, pcpi_insn, busy, done, err_timeout
  );

endinterface

// File: rtl/matrix_pcpi_loader.sv
// Purpose : turns an operand stream into custom-0 WRITE insns, then START, wait, CLEAR.
// Latency : an accepted beat appears as a WRITE one cycle later; START one cycle after last WRITE.
// Backpr. : s_ready is high for the whole LOAD phase only; no insn is ever re-issued.
// Ports   : clk, resetn (async, active low); ctl = matrix_pcpi_loader_if.master
//           (cmd_start/cmd_abort, s_valid/s_ready/s_data, pcpi_valid/insn/wait/ready,
//            busy, done, err_timeout).
module matrix_pcpi_loader
  import matrix_pcpi_pkg::*;
#(
  parameter int NUM_WORDS      = 28,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   resetn,
  matrix_pcpi_loader_if.master   ctl
);

  // timer may step one past the limit when the busy->done transition lands on the last cycle
  localparam int                TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam logic [TW-1:0]     TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              pcpi_valid_q;
  logic [31:0]       pcpi_insn_q;
  logic              done_q;
  logic              err_q;
  logic              success_q;

  logic              beat;
  logic              tmo_hit;
  logic              coproc_done;

  assign addr_d      = addr_q + ADDR_W'(1);
  assign timer_d     = timer_q + TW'(1);
  assign beat        = ctl.s_valid & ctl.s_ready;
  assign tmo_hit     = (timer_q >= TMO_LAST);
  assign coproc_done = ctl.pcpi_ready & ~ctl.pcpi_wait;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      timer_q      <= '0;
      pcpi_valid_q <= 1'b0;
      pcpi_insn_q  <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      success_q    <= 1'b0;
    end else begin
      // strobes default low so every insn lasts exactly one cycle
      pcpi_valid_q <= 1'b0;
      pcpi_insn_q  <= '0;
      done_q       <= 1'b0;

      case (state_q)
        IDLE: begin
          if (ctl.cmd_start) begin
            state_q   <= LOAD;
            addr_q    <= '0;
            err_q     <= 1'b0;
            success_q <= 1'b0;
          end
        end

        LOAD: begin
          // an abort wins over a beat arriving in the same cycle; that beat is lost
          if (ctl.cmd_abort) begin
            state_q <= CLEAR;
          end else if (beat) begin
            pcpi_valid_q <= 1'b1;
            pcpi_insn_q  <= encode_insn(F3_WRITE, addr_q, ctl.s_data);
            addr_q       <= addr_d;
            if (addr_q == LAST_ADDR) begin
              state_q <= START;
            end
          end
        end

        START: begin
          if (ctl.cmd_abort) begin
            state_q <= CLEAR;
          end else begin
            pcpi_valid_q <= 1'b1;
            pcpi_insn_q  <= encode_insn(F3_START, '0, '0);
            timer_q      <= '0;
            state_q      <= WAIT_BUSY;
          end
        end

        WAIT_BUSY: begin
          // pcpi_ready is stale from the WRITEs here; only the rise of pcpi_wait matters
          timer_q <= timer_d;
          if (ctl.cmd_abort) begin
            state_q <= CLEAR;
          end else if (ctl.pcpi_wait) begin
            state_q <= WAIT_DONE;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            state_q <= CLEAR;
          end
        end

        WAIT_DONE: begin
          timer_q <= timer_d;
          if (ctl.cmd_abort) begin
            state_q <= CLEAR;
          end else if (coproc_done) begin
            success_q <= 1'b1;
            state_q   <= CLEAR;
          end else if (tmo_hit) begin
            err_q   <= 1'b1;
            state_q <= CLEAR;
          end
        end

        CLEAR: begin
          pcpi_valid_q <= 1'b1;
          pcpi_insn_q  <= encode_insn(F3_CLEAR, '0, '0);
          done_q       <= success_q;
          success_q    <= 1'b0;
          state_q      <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign ctl.s_ready     = (state_q == LOAD);
  assign ctl.busy        = (state_q != IDLE);
  assign ctl.pcpi_valid  = pcpi_valid_q;
  assign ctl.pcpi_insn   = pcpi_insn_q;
  assign ctl.done        = done_q;
  assign ctl.err_timeout = err_q;

endmodule

// File: tb/tb_matrix_pcpi_loader.sv
// Purpose : randomized self-checking bench for matrix_pcpi_loader with a coprocessor model.
// Latency : expected insn timing derived from job-level rules (beat -> WRITE, START, wait, CLEAR).
// Backpr. : operand beats are offered with continuous, alternating or random valid patterns.
module tb_matrix_pcpi_loader;

  localparam int NW  = 28;
  localparam int TMO = 64;

  logic clk;
  logic resetn;

  matrix_pcpi_loader_if ifc();

  matrix_pcpi_loader #(
    .NUM_WORDS      (NW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .ctl    (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] insn;
    logic        dn;
  } ev_t;

  ev_t obs[$];
  ev_t exp_q[$];

  int checks     = 0;
  int failures   = 0;
  int cyc        = 0;
  int cop_cnt    = 0;
  int cop_wait_n = 8;
  int done_stray = 0;
  int err_rise   = -1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // instruction image built from the field layout with plain arithmetic
  function automatic logic [31:0] mk(input int f3, input int addr, input int val);
    logic [31:0] r;
    r = 32'd11 + (32'(addr) << 7) + (32'(f3) << 12) + (32'(val & 32'hFFFF) << 15);
    return r;
  endfunction

  function automatic ev_t ev(input int c, input logic [31:0] insn, input logic dn);
    ev_t e;
    e.cyc  = c;
    e.insn = insn;
    e.dn   = dn;
    return e;
  endfunction

  // one clock: sample outputs 1 time unit after the edge, then run the coprocessor model
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    if (ifc.pcpi_valid === 1'b1) obs.push_back(ev(cyc, ifc.pcpi_insn, ifc.done));
    else if (ifc.done !== 1'b0) done_stray++;
    if (ifc.err_timeout === 1'b1 && err_rise < 0) err_rise = cyc;
    if (cop_cnt > 0) begin
      cop_cnt--;
      if (cop_cnt == 0) begin
        ifc.pcpi_wait  = 1'b0;
        ifc.pcpi_ready = 1'b1;
      end
    end
    if (ifc.pcpi_valid === 1'b1 && ifc.pcpi_insn == mk(7, 0, 0) && cop_wait_n > 0) begin
      cop_cnt        = cop_wait_n;
      ifc.pcpi_wait  = 1'b1;
      ifc.pcpi_ready = 1'b0;
    end
  endtask

  // mode: 0 continuous, 1 valid every other cycle, 2 random ~60%
  // wait_n <= 0: coprocessor never raises pcpi_wait
  task automatic run_job(input int mode, input bit seq_vals, input int wait_n,
                         input int abort_at, input bit start_in_wait);
    int  offered;
    int  abort_c;
    int  s_cyc;
    int  exp_err;
    int  n;
    bit  ended;
    bit  sent;
    int  vals[$];
    int  offer_cyc[$];
    offered = 0; abort_c = -1; ended = 1'b0; sent = 1'b0;
    obs.delete();
    exp_q.delete();
    done_stray = 0;
    cop_wait_n = wait_n;

    err_rise = -1;
    ifc.cmd_start = 1'b1;
    step();
    ifc.cmd_start = 1'b0;
    chk("start_busy", 32'(ifc.busy), 32'd1);
    chk("start_rdy", 32'(ifc.s_ready), 32'd1);
    chk("start_err_clr", 32'(ifc.err_timeout), 32'd0);

    for (int it = 0; it < 2000 && offered < NW; it++) begin
      bit v;
      int d;
      case (mode)
        0:       v = 1'b1;
        1:       v = (it % 2 == 1);
        default: v = ($urandom_range(0, 99) < 60);
      endcase
      d = seq_vals ? offered + 1 : int'($urandom_range(0, 65535));
      ifc.s_valid = v;
      ifc.s_data  = 16'(d);
      if (v && offered == abort_at) ifc.cmd_abort = 1'b1;
      step();
      ifc.s_valid = 1'b0;
      if (ifc.cmd_abort) begin
        ifc.cmd_abort = 1'b0;
        abort_c = cyc;
        break;
      end
      if (v) begin
        vals.push_back(d);
        offer_cyc.push_back(cyc);
        offered++;
      end
    end

    for (int t = 0; t < 300 && !ended; t++) begin
      if (start_in_wait && !sent && cop_cnt > 0 && cop_cnt < cop_wait_n) begin
        ifc.cmd_start = 1'b1;
        sent = 1'b1;
      end
      step();
      ifc.cmd_start = 1'b0;
      if (ifc.busy === 1'b0) ended = 1'b1;
    end
    chk("job_end", 32'(ended), 32'd1);
    if (start_in_wait) chk("start_in_wait_sent", 32'(sent), 32'd1);
    repeat (4) step();
    chk("idle_rdy", 32'(ifc.s_ready), 32'd0);

    // reference: k-th accepted beat -> WRITE addr k in the beat's cycle, then START/CLEAR
    for (int i = 0; i < vals.size(); i++)
      exp_q.push_back(ev(offer_cyc[i], mk(0, i, vals[i]), 1'b0));
    exp_err = -1;
    if (abort_c >= 0) begin
      exp_q.push_back(ev(abort_c + 1, mk(5, 0, 0), 1'b0));
    end else if (offered < NW) begin
      chk("beats_offered", 32'(offered), 32'(NW));
    end else begin
      s_cyc = offer_cyc[NW-1] + 1;
      exp_q.push_back(ev(s_cyc, mk(7, 0, 0), 1'b0));
      if (wait_n <= 0) begin
        exp_err = s_cyc + TMO;
        exp_q.push_back(ev(s_cyc + TMO + 1, mk(5, 0, 0), 1'b0));
      end else begin
        exp_q.push_back(ev(s_cyc + wait_n + 2, mk(5, 0, 0), 1'b1));
      end
    end
    chk("err_rise_cyc", 32'(err_rise), 32'(exp_err));
    chk("done_stray", 32'(done_stray), 32'd0);

    chk("n_insn", 32'(obs.size()), 32'(exp_q.size()));
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("insn%0d", i), obs[i].insn, exp_q[i].insn);
      chk($sformatf("cyc%0d", i), 32'(obs[i].cyc), 32'(exp_q[i].cyc));
      chk($sformatf("done%0d", i), 32'(obs[i].dn), 32'(exp_q[i].dn));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn         = 1'b0;
    ifc.cmd_start  = 1'b0;
    ifc.cmd_abort  = 1'b0;
    ifc.s_valid    = 1'b0;
    ifc.s_data     = 16'h0;
    ifc.pcpi_wait  = 1'b0;
    ifc.pcpi_ready = 1'b1;

    step();
    step();
    chk("rst_pcpi_valid", 32'(ifc.pcpi_valid), 32'd0);
    chk("rst_pcpi_insn", ifc.pcpi_insn, 32'd0);
    chk("rst_s_ready", 32'(ifc.s_ready), 32'd0);
    chk("rst_done", 32'(ifc.done), 32'd0);
    chk("rst_err", 32'(ifc.err_timeout), 32'd0);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    #2 resetn = 1'b1;

    // full job, continuous stream, values 1..28, coprocessor busy for 8 cycles
    run_job(0, 1'b1, 8, -1, 1'b0);
    if (obs.size() >= 30) begin
      chk("addr5_image", obs[5].insn, 32'h0003028B);
      chk("start_image", obs[28].insn, 32'h0000700B);
      chk("clear_image", obs[29].insn, 32'h0000500B);
    end else begin
      chk("job_a_len", 32'(obs.size()), 32'd30);
    end

    // valid low every other cycle
    run_job(1, 1'b0, 5, -1, 1'b0);
    // coprocessor never goes busy -> timeout
    run_job(2, 1'b0, 0, -1, 1'b0);
    chk("err_sticky", 32'(ifc.err_timeout), 32'd1);
    // next job clears the sticky flag at cmd_start
    run_job(0, 1'b0, 3, -1, 1'b0);
    // abort together with beat 10
    run_job(2, 1'b0, 8, 10, 1'b0);
    // cmd_start during WAIT_DONE is ignored
    run_job(0, 1'b0, 10, -1, 1'b1);

    // async reset in the middle of LOAD
    ifc.cmd_start = 1'b1;
    step();
    ifc.cmd_start = 1'b0;
    ifc.s_valid = 1'b1;
    ifc.s_data  = 16'(int'($urandom_range(0, 65535)));
    repeat (5) step();
    chk("pre_rst_valid", 32'(ifc.pcpi_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ifc.pcpi_valid), 32'd0);
    chk("mid_rst_busy", 32'(ifc.busy), 32'd0);
    chk("mid_rst_rdy", 32'(ifc.s_ready), 32'd0);
    ifc.s_valid    = 1'b0;
    cop_cnt        = 0;
    ifc.pcpi_wait  = 1'b0;
    ifc.pcpi_ready = 1'b1;
    #2 resetn = 1'b1;

    // fresh job after reset starts at addr 0
    run_job(2, 1'b0, int'($urandom_range(1, 20)), -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
